// File: rtl/load_store_unit.sv
// Memory-access stage: issues handshaked data-memory loads/stores and emits a
// registered writeback packet; non-memory ops pass through in one cycle.
// Optional macro LSU_TIMEOUT_EN enables a WAIT-state timeout that raises bus_err.
module load_store_unit #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned REG_WIDTH      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ls_load,
  input  logic                 ls_store,
  input  logic [1:0]           ls_size,
  input  logic                 ls_unsigned,
  input  logic [BUS_WIDTH-1:0] ls_addr,
  input  logic [BUS_WIDTH-1:0] ls_wdata,
  input  logic [REG_WIDTH-1:0] ls_rd,
  input  logic                 ls_rde,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_valid,
  output logic [REG_WIDTH-1:0] wb_rd,
  output logic                 wb_rde,
  output logic [BUS_WIDTH-1:0] wb_data,
  output logic                 misaligned,
  output logic                 bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state, state_d;
  logic                 mem_req_d, mem_wr_d, wb_valid_d, wb_rde_d, misaligned_d, bus_err_d;
  logic [BUS_WIDTH-1:0] mem_addr_d, mem_wdata_d, wb_data_d;
  logic [3:0]           mem_be_d;
  logic [REG_WIDTH-1:0] wb_rd_d;

  // Packet attributes held for the duration of a memory access
  logic                 cap_load, cap_load_d, cap_uns, cap_uns_d, cap_rde, cap_rde_d;
  logic [1:0]           cap_size, cap_size_d, cap_off, cap_off_d;

  logic                 is_store, is_load, is_mem, mis, sz_byte, sz_half;
  logic [BUS_WIDTH-1:0] lane, load_val;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign in_ready = (state == S_IDLE) && !reset;

  // Decode the incoming packet; a load+store collision is treated as a store
  always_comb begin
    is_store = ls_store;
    is_load  = ls_load && !ls_store;
    is_mem   = is_store || is_load;
    sz_byte  = (ls_size == 2'd0);
    sz_half  = (ls_size == 2'd1);
    mis      = (sz_half && ls_addr[0]) || (!sz_byte && !sz_half && (ls_addr[1:0] != 2'b00));
  end

  // Select and extend the addressed lane of the returned read data
  always_comb begin
    lane = mem_rdata >> {cap_off, 3'b000};
    case (cap_size)
      2'd0:    load_val = cap_uns ? {{(BUS_WIDTH-8){1'b0}}, lane[7:0]}
                                  : {{(BUS_WIDTH-8){lane[7]}}, lane[7:0]};
      2'd1:    load_val = cap_uns ? {{(BUS_WIDTH-16){1'b0}}, lane[15:0]}
                                  : {{(BUS_WIDTH-16){lane[15]}}, lane[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    mem_req_d    = mem_req;
    mem_wr_d     = mem_wr;
    mem_addr_d   = mem_addr;
    mem_be_d     = mem_be;
    mem_wdata_d  = mem_wdata;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd;
    wb_rde_d     = wb_rde;
    wb_data_d    = wb_data;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    cap_load_d   = cap_load;
    cap_uns_d    = cap_uns;
    cap_rde_d    = cap_rde;
    cap_size_d   = cap_size;
    cap_off_d    = cap_off;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt;
`endif
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          wb_rd_d    = ls_rd;
          cap_load_d = is_load;
          cap_uns_d  = ls_unsigned;
          cap_rde_d  = ls_rde && (ls_rd != '0);
          cap_size_d = ls_size;
          cap_off_d  = ls_addr[1:0];
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ls_addr;
            wb_rde_d   = ls_rde && (ls_rd != '0);
          end else if (mis) begin
            wb_valid_d   = 1'b1;
            wb_data_d    = '0;
            wb_rde_d     = 1'b0;
            misaligned_d = 1'b1;
          end else begin
            state_d    = S_WAIT;
            mem_req_d  = 1'b1;
            mem_wr_d   = is_store;
            mem_addr_d = {ls_addr[BUS_WIDTH-1:2], 2'b00};
            if (sz_byte) begin
              mem_be_d    = 4'(4'b0001 << ls_addr[1:0]);
              mem_wdata_d = {(BUS_WIDTH/8){ls_wdata[7:0]}};
            end else if (sz_half) begin
              mem_be_d    = 4'(4'b0011 << ls_addr[1:0]);
              mem_wdata_d = {(BUS_WIDTH/16){ls_wdata[15:0]}};
            end else begin
              mem_be_d    = 4'hF;
              mem_wdata_d = ls_wdata;
            end
`ifdef LSU_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = cap_load ? load_val : '0;
          wb_rde_d   = cap_load && cap_rde;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
          wb_rde_d   = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_rde     <= 1'b0;
      wb_data    <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      cap_load   <= 1'b0;
      cap_uns    <= 1'b0;
      cap_rde    <= 1'b0;
      cap_size   <= '0;
      cap_off    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_d;
      mem_req    <= mem_req_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_rd      <= wb_rd_d;
      wb_rde     <= wb_rde_d;
      wb_data    <= wb_data_d;
      misaligned <= misaligned_d;
      bus_err    <= bus_err_d;
      cap_load   <= cap_load_d;
      cap_uns    <= cap_uns_d;
      cap_rde    <= cap_rde_d;
      cap_size   <= cap_size_d;
      cap_off    <= cap_off_d;
`ifdef LSU_TIMEOUT_EN
      cnt        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        ls_load, ls_store, ls_unsigned, ls_rde;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic [4:0]  ls_rd;
  logic        mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_rde, misaligned, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_chk  = 0;
  int n_pass = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ls_load(ls_load), .ls_store(ls_store), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rd(ls_rd), .ls_rde(ls_rde),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rde(wb_rde), .wb_data(wb_data),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance past the next rising edge; outputs then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one packet for exactly one accepting edge
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rde);
    in_valid = 1'b1; ls_load = ld; ls_store = st; ls_size = sz; ls_unsigned = uns;
    ls_addr = addr; ls_wdata = wd; ls_rd = rd; ls_rde = rde;
    tick();
    in_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0; ls_size = 2'd0;
    ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0; ls_rd = '0; ls_rde = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_req",  32'(mem_req),  32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data",  wb_data,       32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Pass-through
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    chk("pt_wb_valid", 32'(wb_valid), 32'd1);
    chk("pt_wb_data",  wb_data,       32'h0000_1234);
    chk("pt_wb_rd",    32'(wb_rd),    32'd5);
    chk("pt_wb_rde",   32'(wb_rde),   32'd1);
    chk("pt_mem_req",  32'(mem_req),  32'd0);
    tick();
    chk("pt_pulse",    32'(wb_valid), 32'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req),  32'd0);
    chk("idle_ack_wb",  32'(wb_valid), 32'd0);

    // Signed byte load from lane 3
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    chk("lb_req",      32'(mem_req),  32'd1);
    chk("lb_wr",       32'(mem_wr),   32'd0);
    chk("lb_addr",     mem_addr,      32'h0000_0100);
    chk("lb_be",       32'(mem_be),   32'h8);
    chk("lb_in_ready", 32'(in_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_FF7F;
    tick();
    mem_ack = 1'b0;
    chk("lb_req_drop", 32'(mem_req),  32'd0);
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_wb_data",  wb_data,       32'hFFFF_FF80);
    chk("lb_wb_rde",   32'(wb_rde),   32'd1);
    chk("lb_wb_rd",    32'(wb_rd),    32'd7);
    chk("b2b_ready",   32'(in_ready), 32'd1);

    // Same packet unsigned, accepted on the edge after wb_valid (back-to-back)
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    chk("lbu_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("lbu_wb_data", wb_data, 32'h0000_0080);

    // Store half with ack delayed 3 cycles; load+store collision acts as store
    issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sh_req_%0d", i),   32'(mem_req),  32'd1);
      chk($sformatf("sh_wr_%0d", i),    32'(mem_wr),   32'd1);
      chk($sformatf("sh_be_%0d", i),    32'(mem_be),   32'hC);
      chk($sformatf("sh_addr_%0d", i),  mem_addr,      32'h0000_0200);
      chk($sformatf("sh_wdata_%0d", i), mem_wdata,     32'hABCD_ABCD);
      chk($sformatf("sh_rdy_%0d", i),   32'(in_ready), 32'd0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_wb_rde",   32'(wb_rde),   32'd0);
    chk("sh_req_drop", 32'(mem_req),  32'd0);

    // Byte store replication
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0601, 32'h0000_00A5, 5'd1, 1'b0);
    chk("sb_be",    32'(mem_be), 32'h2);
    chk("sb_wdata", mem_wdata,   32'hA5A5_A5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Signed half load from upper lane, and word load
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0402, 32'h0, 5'd3, 1'b1);
    chk("lh_be", 32'(mem_be), 32'hC);
    mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_ack = 1'b0;
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 5'd3, 1'b1);
    chk("lw_be", 32'(mem_be), 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);

    // Misaligned word load
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0301, 32'h0, 5'd9, 1'b1);
    chk("mis_req",   32'(mem_req),    32'd0);
    chk("mis_flag",  32'(misaligned), 32'd1);
    chk("mis_valid", 32'(wb_valid),   32'd1);
    chk("mis_rde",   32'(wb_rde),     32'd0);
    chk("mis_ready", 32'(in_ready),   32'd1);
    tick();
    chk("mis_pulse", 32'(misaligned), 32'd0);

    // Destination x0 never writes back
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0055, 32'h0, 5'd0, 1'b1);
    chk("x0_valid", 32'(wb_valid), 32'd1);
    chk("x0_rde",   32'(wb_rde),   32'd0);

    // Reset mid-WAIT abandons the access
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 5'd4, 1'b1);
    chk("rw_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req_drop", 32'(mem_req),  32'd0);
    chk("rw_ready",    32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rw_ready_rel", 32'(in_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ack = 1'b0;
      chk($sformatf("rw_no_wb_%0d", i), 32'(wb_valid), 32'd0);
      chk($sformatf("rw_no_req_%0d", i), 32'(mem_req), 32'd0);
    end

`ifdef LSU_TIMEOUT_EN
    // Access with no ack times out after 16 cycles of mem_req
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0700, 32'h0, 5'd6, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
      tick();
    end
    chk("to_req_drop", 32'(mem_req),  32'd0);
    chk("to_bus_err",  32'(bus_err),  32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_wb_rde",   32'(wb_rde),   32'd0);
`else
    chk("no_bus_err", 32'(bus_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage of the RISC-V pipeline. It sits directly downstream of the execute stage and consumes its ALU result, rs2 data and destination register. For loads and stores it performs a handshaked data-memory access, then produces a registered writeback packet. Non-memory instructions pass through with 1-cycle latency. The stage stalls upstream via in_ready while a memory access is outstanding.

Parameters:
BUS_WIDTH, 32, data/address width
REG_WIDTH, 5, register index width
TIMEOUT_CYCLES, 16, wait-state limit; used only with LSU_TIMEOUT_EN

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  execute-stage packet valid
in_ready  output  1  stage can accept a packet
ls_load  input  1  packet is a load
ls_store  input  1  packet is a store
ls_size  input  2  0=byte, 1=half, 2=word; 3 is treated as word
ls_unsigned  input  1  zero-extend load (LBU/LHU)
ls_addr  input  BUS_WIDTH  ALU result: effective address, or result for non-memory ops
ls_wdata  input  BUS_WIDTH  rs2 data for stores
ls_rd  input  REG_WIDTH  destination register
ls_rde  input  1  destination-register write enable
mem_req  output  1  data-memory request
mem_wr  output  1  1=write, 0=read
mem_addr  output  BUS_WIDTH  word-aligned address
mem_be  output  4  byte enables
mem_wdata  output  BUS_WIDTH  lane-replicated store data
mem_rdata  input  BUS_WIDTH  read data, valid with mem_ack
mem_ack  input  1  memory completion
wb_valid  output  1  writeback packet valid, 1-cycle pulse
wb_rd  output  REG_WIDTH  writeback register
wb_rde  output  1  writeback enable
wb_data  output  BUS_WIDTH  writeback data
misaligned  output  1  1-cycle pulse: misaligned access dropped
bus_err  output  1  1-cycle pulse: access timed out

Behaviour:
- Reset: all outputs 0, FSM=IDLE, in_ready=0 while reset is held. Reset asserted mid-access drops mem_req immediately; the access is abandoned.
- FSM states: IDLE, WAIT. in_ready = (state==IDLE) && !reset.
- Accept: in_valid && in_ready at a rising edge.
- IDLE, accept, neither load nor store: next cycle wb_valid=1, wb_data=ls_addr, wb_rd=ls_rd, wb_rde=ls_rde. State stays IDLE.
- Misaligned access (half with addr[0]=1; word with addr[1:0]!=0): no memory access. Next cycle wb_valid=1, wb_rde=0, misaligned=1. State stays IDLE.
- ls_load and ls_store both high: treated as a store.
- Aligned load or store: next cycle mem_req=1 and state=WAIT.
  - mem_addr = {addr[31:2],2'b00}.
  - mem_be: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'hF.
  - mem_wdata: byte replicated into 4 lanes; half replicated into 2 lanes; word as-is.
- WAIT: mem_* outputs held stable until mem_ack. mem_ack is sampled only while mem_req=1; mem_ack seen in IDLE is ignored.
- On mem_ack: the next cycle has mem_req=0, state=IDLE, wb_valid=1.
  - Load: wb_data = selected lane, sign-extended, or zero-extended if ls_unsigned. wb_rde = captured ls_rde.
  - Store: wb_rde=0.
- Minimum memory-op latency: accept at edge N, mem_req visible N+1, ack in the same cycle, wb_valid at N+2.
- Back-to-back: a new packet may be accepted on the edge that the previous wb_valid is asserted.
- Writes to x0: wb_rde is forced to 0 when wb_rd=0.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If TIMEOUT_CYCLES cycles elapse without mem_ack, the FSM returns to IDLE and mem_req drops. The next cycle has bus_err=1, wb_valid=1, wb_rde=0. The counter clears on every entry to WAIT.
- Undefined: no counter; WAIT persists indefinitely; bus_err is tied 0.

Test Plan:
- Pass-through: ls_addr=0x0000_1234, rd=5, rde=1, no load/store -> one cycle later wb_valid=1, wb_data=0x0000_1234, wb_rd=5.
- Load byte signed: addr=0x103, mem_rdata=0x80FF_FF7F -> mem_addr=0x100, mem_be=4'b1000, wb_data=0xFFFF_FF80. Same packet with ls_unsigned=1 -> wb_data=0x0000_0080.
- Store half: addr=0x202, wdata=0x1234_ABCD, mem_ack delayed 3 cycles -> mem_be=4'b1100, mem_wdata=0xABCD_ABCD held 4 cycles, in_ready=0 throughout, then wb_valid=1 with wb_rde=0.
- Misaligned word load: addr=0x301 -> mem_req stays 0, misaligned=1, wb_rde=0 one cycle later.
- Reset asserted mid-WAIT -> mem_req=0 immediately; after release in_ready=1 and no wb_valid appears.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ack never asserted -> mem_req drops after 16 cycles, then bus_err=1 and wb_valid=1 with wb_rde=0.
